// File: rtl/instr_decode_stage.sv
// instr_decode_stage
// RV32I decode stage with a two-entry skid buffer between fetch and execute.
// Raw instruction words are decoded combinationally. The decoded payload is captured
// when a word is accepted and then held until execute consumes it.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   in_valid/in_ready      fetch handshake; in_ready is registered
//   in_instr, in_pc        raw instruction word and its address
//   flush                  synchronous kill of held and incoming instructions
//   out_valid/out_ready    execute handshake
//   out_op .. out_illegal  decoded payload of the instruction in the main entry
module instr_decode_stage (
   input  logic        clk,
   input  logic        resetn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [6:0]  out_op,
   output logic [2:0]  out_opcode,
   output logic [6:0]  out_funct7,
   output logic [4:0]  out_shamt,
   output logic [31:0] out_imm,
   output logic [4:0]  out_rs1,
   output logic [4:0]  out_rs2,
   output logic [4:0]  out_rd,
   output logic [31:0] out_pc,
   output logic        out_illegal
);

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpFence  = 7'b0001111;
   localparam logic [6:0] OpAluImm = 7'b0010011;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpAluReg = 7'b0110011;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpSystem = 7'b1110011;

   typedef struct packed {
      logic [6:0]  op;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [4:0]  shamt;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic        illegal;
   } payload_t;

   payload_t dec;
   payload_t main_q, main_d;
   payload_t skid_q, skid_d;
   logic     main_valid_q, main_valid_d;
   logic     skid_valid_q, skid_valid_d;
   logic     in_ready_q, in_ready_d;

   // Combinational decode of the incoming word
   always_comb begin
      logic [31:0] w;
      w           = in_instr;
      dec         = '0;
      dec.op      = w[6:0];
      dec.funct3  = w[14:12];
      dec.funct7  = w[31:25];
      dec.shamt   = w[24:20];
      dec.rs1     = w[19:15];
      dec.rs2     = w[24:20];
      dec.rd      = w[11:7];
      dec.pc      = in_pc;
      dec.illegal = 1'b0;
      dec.imm     = '0;
      unique case (w[6:0])
         OpLoad, OpSystem: dec.imm = {{20{w[31]}}, w[31:20]};
         OpJalr: begin
            dec.imm     = {{20{w[31]}}, w[31:20]};
            dec.illegal = (w[14:12] != 3'b000);
         end
         OpAluImm: begin
            dec.imm = {{20{w[31]}}, w[31:20]};
            if (w[14:12] == 3'b001) begin
               dec.illegal = (w[31:25] != 7'b0000000);
            end else if (w[14:12] == 3'b101) begin
               dec.illegal = (w[31:25] != 7'b0000000) && (w[31:25] != 7'b0100000);
            end
         end
         OpStore: begin
            dec.imm = {{20{w[31]}}, w[31:25], w[11:7]};
            dec.rd  = '0;
         end
         OpBranch: begin
            dec.imm     = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            dec.rd      = '0;
            dec.illegal = (w[14:13] == 2'b01);
         end
         OpLui, OpAuipc: dec.imm = {w[31:12], 12'b0};
         OpJal: dec.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
         OpAluReg: begin
            // Only base ops (funct7 = 0) and SUB/SRA (funct7 = 0100000) exist
            if (w[31:25] == 7'b0100000) begin
               dec.illegal = (w[14:12] != 3'b000) && (w[14:12] != 3'b101);
            end else begin
               dec.illegal = (w[31:25] != 7'b0000000);
            end
         end
         OpFence: dec.imm = '0;
         default: dec.illegal = 1'b1;
      endcase
      if (w[1:0] != 2'b11) begin
         dec.illegal = 1'b1;
      end
   end

   // Skid buffer next-state
   always_comb begin
      logic accept;
      logic main_free;
      accept       = in_valid && in_ready_q;
      // Main can take a new occupant if it is empty or being drained this cycle
      main_free    = !main_valid_q || out_ready;
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (main_free) begin
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = accept;
            if (accept) begin
               skid_d = dec;
            end
         end else begin
            main_valid_d = accept;
            if (accept) begin
               main_d = dec;
            end
         end
      end else if (accept) begin
         skid_d       = dec;
         skid_valid_d = 1'b1;
      end
      in_ready_d = !skid_valid_d;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = main_valid_q;
   assign out_op      = main_q.op;
   assign out_opcode  = main_q.funct3;
   assign out_funct7  = main_q.funct7;
   assign out_shamt   = main_q.shamt;
   assign out_imm     = main_q.imm;
   assign out_rs1     = main_q.rs1;
   assign out_rs2     = main_q.rs2;
   assign out_rd      = main_q.rd;
   assign out_pc      = main_q.pc;
   assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Testbench for instr_decode_stage: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_instr_decode_stage;

   logic        clk = 1'b0;
   logic        resetn;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [6:0]  out_op;
   logic [2:0]  out_opcode;
   logic [6:0]  out_funct7;
   logic [4:0]  out_shamt;
   logic [31:0] out_imm;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [4:0]  out_rd;
   logic [31:0] out_pc;
   logic        out_illegal;

   always #5 clk = ~clk;

   instr_decode_stage dut (
      .clk        (clk),
      .resetn     (resetn),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .in_pc      (in_pc),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_op     (out_op),
      .out_opcode (out_opcode),
      .out_funct7 (out_funct7),
      .out_shamt  (out_shamt),
      .out_imm    (out_imm),
      .out_rs1    (out_rs1),
      .out_rs2    (out_rs2),
      .out_rd     (out_rd),
      .out_pc     (out_pc),
      .out_illegal(out_illegal)
   );

   typedef struct packed {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  shamt;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic        illegal;
   } exp_t;

   localparam logic [6:0] OPS [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37,
                                       7'h63, 7'h67, 7'h6F, 7'h73};

   exp_t dut_pl;
   assign dut_pl = {out_op, out_opcode, out_funct7, out_shamt, out_imm, out_rs1, out_rs2,
                    out_rd, out_pc, out_illegal};

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail = 0;

   // Reference decode from the format tables, using signed arithmetic for extension
   function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
      exp_t r;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       ok;
      f3 = w[14:12];
      f7 = w[31:25];
      r = '0;
      r.op = w[6:0];
      r.f3 = f3;
      r.f7 = f7;
      r.shamt = w[24:20];
      r.rs1 = w[19:15];
      r.rs2 = w[24:20];
      r.rd = w[11:7];
      r.pc = pc;
      ok = 1'b1;
      case (w[6:0])
         7'h03, 7'h73: r.imm = 32'($signed(w[31:20]));
         7'h67: begin r.imm = 32'($signed(w[31:20])); ok = (f3 == 0); end
         7'h13: begin
            r.imm = 32'($signed(w[31:20]));
            if (f3 == 1) ok = (f7 == 0);
            if (f3 == 5) ok = f7 inside {7'h00, 7'h20};
         end
         7'h23: begin r.imm = 32'($signed({w[31:25], w[11:7]})); r.rd = 0; end
         7'h63: begin
            r.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            r.rd = 0;
            ok = !(f3 inside {3'd2, 3'd3});
         end
         7'h37, 7'h17: r.imm = w[31:12] * 32'd4096;
         7'h6F: r.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
         7'h33: ok = (f7 == 0) || (f7 == 7'h20 && f3 inside {3'd0, 3'd5});
         7'h0F: r.imm = 0;
         default: ok = 1'b0;
      endcase
      r.illegal = !ok;
      return r;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int k;
      w = $urandom;
      k = $urandom_range(0, 13);
      if (k < 11) w[6:0] = OPS[k];
      if (k == 12) w[1:0] = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h00 : 7'h20;
      return w;
   endfunction

   // Drive one cycle of inputs and advance the reference model at the clock edge
   task automatic cycle(input logic v, input logic [31:0] w, input logic [31:0] pc,
                        input logic rdy, input logic fl);
      logic acc, cons;
      in_valid = v;
      in_instr = w;
      in_pc = pc;
      out_ready = rdy;
      flush = fl;
      @(posedge clk);
      acc = v && (q.size() < 2);
      cons = (q.size() > 0) && rdy;
      if (fl) begin
         q.delete();
      end else begin
         if (cons) q.delete(0);
         if (acc) q.push_back(ref_decode(w, pc));
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0; flush = 0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL reset_hs: valid/ready=%b required 01", {out_valid, in_ready});
      end
      n_checks++;
      if (dut_pl !== '0) begin
         n_fail++;
         $display("FAIL reset_payload: got %h required 0", dut_pl);
      end
      resetn = 1'b1;
      q.delete();
      @(negedge clk);
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL post_reset_hs: valid/ready=%b required 01", {out_valid, in_ready});
      end
   endtask

   task automatic test_addi();
      cycle(1, 32'hFFF10093, 32'h100, 1, 0);
      n_checks++;
      if ({out_valid, out_op, out_opcode, out_rd, out_rs1, out_imm, out_illegal} !==
          {1'b1, 7'h13, 3'd0, 5'd1, 5'd2, 32'hFFFFFFFF, 1'b0}) begin
         n_fail++;
         $display("FAIL addi: v=%b op=%h f3=%h rd=%0d rs1=%0d imm=%h ill=%b", out_valid,
                  out_op, out_opcode, out_rd, out_rs1, out_imm, out_illegal);
      end
      cycle(0, 0, 0, 1, 0);
   endtask

   task automatic test_sub_slli();
      cycle(1, 32'h402081B3, 32'h200, 1, 0);
      n_checks++;
      if ({out_valid, out_op, out_funct7, out_opcode, out_rd, out_rs1, out_rs2, out_illegal} !==
          {1'b1, 7'h33, 7'h20, 3'd0, 5'd3, 5'd1, 5'd2, 1'b0}) begin
         n_fail++;
         $display("FAIL sub: v=%b op=%h f7=%h f3=%h rd=%0d rs1=%0d rs2=%0d ill=%b", out_valid,
                  out_op, out_funct7, out_opcode, out_rd, out_rs1, out_rs2, out_illegal);
      end
      cycle(1, 32'h40109093, 32'h204, 1, 0);
      n_checks++;
      if ({out_valid, out_illegal, out_pc} !== {1'b1, 1'b1, 32'h204}) begin
         n_fail++;
         $display("FAIL slli_bad: v=%b ill=%b pc=%h required 1 1 204", out_valid, out_illegal,
                  out_pc);
      end
      cycle(0, 0, 0, 1, 0);
   endtask

   task automatic test_beq_jal();
      cycle(1, 32'hFE208EE3, 32'h300, 1, 0);
      n_checks++;
      if ({out_op, out_imm, out_rd, out_rs1, out_rs2} !==
          {7'h63, 32'hFFFFFFFC, 5'd0, 5'd1, 5'd2}) begin
         n_fail++;
         $display("FAIL beq: op=%h imm=%h rd=%0d rs1=%0d rs2=%0d", out_op, out_imm, out_rd,
                  out_rs1, out_rs2);
      end
      cycle(1, 32'h001000EF, 32'h304, 1, 0);
      n_checks++;
      if ({out_imm, out_rd} !== {32'h00000800, 5'd1}) begin
         n_fail++;
         $display("FAIL jal: imm=%h rd=%0d required 00000800 1", out_imm, out_rd);
      end
      cycle(0, 0, 0, 1, 0);
   endtask

   task automatic test_back_to_back();
      cycle(1, 32'h00100093, 32'hA0, 0, 0);
      n_checks++;
      if ({out_valid, in_ready, out_pc} !== {2'b11, 32'hA0}) begin
         n_fail++;
         $display("FAIL b2b_first: v=%b rdy=%b pc=%h required 1 1 a0", out_valid, in_ready,
                  out_pc);
      end
      cycle(1, 32'h00200093, 32'hB0, 0, 0);
      n_checks++;
      if ({in_ready, out_pc} !== {1'b0, 32'hA0}) begin
         n_fail++;
         $display("FAIL b2b_full: rdy=%b pc=%h required 0 a0", in_ready, out_pc);
      end
      cycle(1, 32'h00300093, 32'hC0, 0, 0);
      n_checks++;
      if ({out_valid, in_ready, out_pc} !== {2'b10, 32'hA0}) begin
         n_fail++;
         $display("FAIL b2b_hold: v=%b rdy=%b pc=%h required 1 0 a0", out_valid, in_ready,
                  out_pc);
      end
      cycle(1, 32'h00300093, 32'hC0, 1, 0);
      n_checks++;
      if ({out_valid, out_pc} !== {1'b1, 32'hB0}) begin
         n_fail++;
         $display("FAIL b2b_B: v=%b pc=%h required 1 b0", out_valid, out_pc);
      end
      cycle(1, 32'h00300093, 32'hC0, 1, 0);
      n_checks++;
      if ({out_valid, out_pc, out_imm} !== {1'b1, 32'hC0, 32'd3}) begin
         n_fail++;
         $display("FAIL b2b_C: v=%b pc=%h imm=%h required 1 c0 3", out_valid, out_pc, out_imm);
      end
      cycle(0, 0, 0, 1, 0);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_drain: v=%b required 0", out_valid);
      end
   endtask

   task automatic test_flush();
      cycle(1, 32'h00100093, 32'h10, 0, 0);
      cycle(1, 32'h00200093, 32'h14, 0, 0);
      cycle(1, 32'h00300093, 32'h18, 0, 1);
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL flush_full: v/rdy=%b required 01", {out_valid, in_ready});
      end
      cycle(0, 0, 0, 1, 0);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_ghost: v=%b pc=%h required 0", out_valid, out_pc);
      end
      // One entry held, in_ready high: the word accepted with flush is dropped
      cycle(1, 32'h00100093, 32'h20, 0, 0);
      cycle(1, 32'h00200093, 32'h24, 1, 1);
      cycle(0, 0, 0, 1, 0);
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL flush_accept: v/rdy=%b pc=%h required 01", {out_valid, in_ready},
                  out_pc);
      end
   endtask

   task automatic test_illegal_zero();
      cycle(1, 32'h00000000, 32'h40, 1, 0);
      n_checks++;
      if ({out_valid, out_illegal} !== 2'b11) begin
         n_fail++;
         $display("FAIL zero_word: v/ill=%b required 11", {out_valid, out_illegal});
      end
      cycle(0, 0, 0, 1, 0);
   endtask

   task automatic test_async_reset();
      cycle(1, 32'h00100093, 32'h50, 0, 0);
      cycle(1, 32'h00200093, 32'h54, 0, 0);
      in_valid = 0;
      #1 resetn = 1'b0;
      #1;
      n_checks++;
      if ({out_valid, in_ready, out_pc} !== {2'b01, 32'h0}) begin
         n_fail++;
         $display("FAIL async_reset: v=%b rdy=%b pc=%h required 0 1 0", out_valid, in_ready,
                  out_pc);
      end
      q.delete();
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL async_release: v/rdy=%b required 01", {out_valid, in_ready});
      end
   endtask

   task automatic test_random();
      logic [31:0] pc;
      pc = 32'h1000;
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 3) != 0), rand_instr(), pc, 1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 24) == 0));
         pc = pc + 4;
         n_checks++;
         if (out_valid !== (q.size() > 0)) begin
            n_fail++;
            $display("FAIL rand_valid[%0d]: got %b required %b", i, out_valid, q.size() > 0);
         end
         n_checks++;
         if (in_ready !== (q.size() < 2)) begin
            n_fail++;
            $display("FAIL rand_ready[%0d]: got %b required %b", i, in_ready, q.size() < 2);
         end
         if (q.size() > 0) begin
            n_checks++;
            if (dut_pl !== q[0]) begin
               n_fail++;
               $display("FAIL rand_payload[%0d]: got %h required %h", i, dut_pl, q[0]);
            end
         end
      end
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 0, 1, 0);
   endtask

   initial begin
      test_reset();
      test_addi();
      test_sub_slli();
      test_beq_jal();
      test_back_to_back();
      test_flush();
      test_illegal_zero();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
